pipeline_fetch_ctrl: RTL and testbench
======================================

# pipeline_fetch_ctrl

Fetch/PC-sequencing stage that consumes the branch unit's next-PC select and kill requests. Owns the fetch PC, the F→D→X instruction/PC/valid pipeline registers, bubble insertion on stall and kill, and a saturating kill counter. Its `validD`, `validX`, `instD` and `instX` outputs feed back into the branch unit in the following cycle.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC of the first fetch after reset.
- `NOP`, default 32'h0000_0013 (`addi x0,x0,0`): instruction word inserted for every bubble.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `PCSel_F_in`  in  3  next-PC select from the branch unit:
  - 0: PCF+4
  - 1: PCF+immF
  - 2: ALU result in X (JALR)
  - 3: PCD+immD
  - 4–7: reserved, treated as 0.
- `killD_req`  in  1  invalidate the instruction moving F→D this edge.
- `killX_req`  in  1  invalidate the instruction moving D→X this edge.
- `stall`  in  1  load-use hold of F and D.
- `instF_in`  in  32  IMEM read data for address `PCF`, combinational.
- `immF`  in  32  JAL immediate of `instF_in`, sign-extended.
- `immD`  in  32  B immediate of `instD`, sign-extended.
- `aluX`  in  32  ALU result of the X-stage instruction.
- `PCF`, `PCD`, `PCX`  out  32  stage PCs.
- `instD`, `instX`  out  32  stage instruction words.
- `validF`, `validD`, `validX`  out  1  stage valid bits.
- `kill_cnt`  out  16  saturating count of killed slots.

## Operation
- **Reset** (`rst_n`=0 at an edge):
  - PCF=PCD=PCX=`RESET_PC`.
  - instD=instX=`NOP`.
  - validF=validD=validX=0.
  - kill_cnt=0.
- **Start-up:** the first edge with `rst_n`=1 sets validF=1 and holds PCF at `RESET_PC`. While validF=0, `PCSel_F_in`, `stall` and the kill inputs are ignored.
- **Next PC** (validF=1):
  - Select 0 (and reserved 4–7): PCF+4.
  - Select 1: PCF+immF.
  - Select 2: {aluX[31:1],1'b0}.
  - Select 3: PCD+immD.
  - All adds are 32-bit modulo 2^32; carries are dropped, and wrap from 32'hFFFF_FFFC to 0 is legal.
- **Redirect:** `PCSel_F_in` of 2 or 3. A redirect overrides `stall` in the same cycle: PCF takes the redirect target, and the kills apply as below.
- **Normal advance** (no stall, or redirect):
  - PCD←PCF, instD←instF_in, validD←validF & ~killD_req.
  - PCX←PCD, instX←instD, validX←validD & ~killX_req.
  - A slot whose new valid is 0 loads `NOP` into its inst register; its PC register still advances.
- **Stall without redirect:**
  - PCF, PCD, instD and validD hold.
  - X receives a bubble: validX←0, instX←`NOP`, PCX←PCD.
  - Kill inputs are ignored.
- **kill_cnt:**
  - Increments by 1 for each valid slot killed at an edge, i.e. by (validF&killD_req) + (validD&killX_req). Each edge therefore adds 0, 1 or 2.
  - Saturates at 16'hFFFF.
  - Stall bubbles are not counted.
- **Mid-operation reset** (`rst_n` low): overrides every other input; all state returns to reset values at that edge.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `PCSel_F_in` sampled at edge n gives the new PCF after edge n. The target instruction is in D after edge n+1.
- Kill requests sampled at edge n affect the valid bits written at edge n. The branch unit issues them in the same cycle as the redirect select.
- Taken branch resolved in D costs one bubble. JALR resolved in X costs two bubbles.
- IMEM must return `instF_in` for `PCF` within the same cycle.

## Test plan
- **Reset and first fetch.** `rst_n`=0 for 2 edges, then 1, with `RESET_PC`=32'h100. Required:
  - All valids 0, instD=instX=32'h13 and kill_cnt=0 during reset.
  - validF=1 with PCF=32'h100 after the first release edge.
  - PCF=32'h104 after the next edge.
- **Sequential flow and JAL.** PCSel=0 for 3 edges, then PCSel=1 with immF=32'hFFFF_FFF0 at PCF=32'h10C. Required: PCF=32'h0FC, no kills, validD=validX=1 once filled.
- **Taken branch in D.** PCD=32'h200, immD=32'h40, PCSel=3, killD_req=1. Required:
  - PCF=32'h240.
  - Next validD=0 with instD=NOP; validX=1 with PCX=32'h200.
  - kill_cnt+1.
- **JALR in X.** aluX=32'h0000_0301, PCSel=2, killD_req=killX_req=1. Required: PCF=32'h300, validD=validX=0 next cycle, kill_cnt+2.
- **Stall, then redirect overriding stall.**
  - stall=1 for 2 edges with PCSel=0: PCF, PCD and instD hold; validX=0 and instX=NOP on both edges.
  - Then stall=1 with PCSel=3: redirect taken and stall ignored.
- **Saturation and reset mid-run.**
  - Force kill_cnt to 16'hFFFE and apply a JALR kill (+2): kill_cnt=16'hFFFF.
  - Assert `rst_n`=0 mid-stream: all outputs equal reset values after that edge.

Source files
------------

// File: rtl/pipeline_fetch_ctrl.sv
// Fetch-stage PC sequencer with the F->D->X instruction/PC/valid pipeline.
// Redirects, kills and stalls come from the branch unit; outputs are all registered.
module pipeline_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  PCSel_F_in,
  input  logic        killD_req,
  input  logic        killX_req,
  input  logic        stall,
  input  logic [31:0] instF_in,
  input  logic [31:0] immF,
  input  logic [31:0] immD,
  input  logic [31:0] aluX,
  output logic [31:0] PCF,
  output logic [31:0] PCD,
  output logic [31:0] PCX,
  output logic [31:0] instD,
  output logic [31:0] instX,
  output logic        validF,
  output logic        validD,
  output logic        validX,
  output logic [15:0] kill_cnt
);

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_JAL  = 3'd1,
    SEL_JALR = 3'd2,
    SEL_BR   = 3'd3
  } pc_sel_e;

  logic [31:0] pc_next;
  logic        redirect;
  logic        hold;
  logic        kill_d;
  logic        kill_x;
  logic        next_valid_d;
  logic        next_valid_x;
  logic [1:0]  kill_inc;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_next;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    pc_next  = PCF + 32'd4;
    redirect = 1'b0;
    case (pc_sel_e'(PCSel_F_in))
      SEL_JAL:  pc_next = PCF + immF;
      SEL_JALR: begin
        pc_next  = aluX & 32'hFFFF_FFFE;
        redirect = 1'b1;
      end
      SEL_BR: begin
        pc_next  = PCD + immD;
        redirect = 1'b1;
      end
      default:  pc_next = PCF + 32'd4;
    endcase
  end

  // Before the first fetch is valid, select/stall/kill inputs have no effect.
  assign hold         = validF & stall & ~redirect;
  assign kill_d       = validF & killD_req;
  assign kill_x       = validF & killX_req;
  assign next_valid_d = validF & ~kill_d;
  assign next_valid_x = validD & ~kill_x;

  assign kill_inc = {1'b0, kill_d} + {1'b0, validD & kill_x};
  assign cnt_sum  = {1'b0, kill_cnt} + {15'd0, kill_inc};
  assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PCF      <= RESET_PC;
      PCD      <= RESET_PC;
      PCX      <= RESET_PC;
      instD    <= NOP;
      instX    <= NOP;
      validF   <= 1'b0;
      validD   <= 1'b0;
      validX   <= 1'b0;
      kill_cnt <= 16'd0;
    end else begin
      validF <= 1'b1;
      if (validF && !hold) PCF <= pc_next;
      PCX <= PCD;
      if (hold) begin
        validX <= 1'b0;
        instX  <= NOP;
      end else begin
        PCD      <= PCF;
        instD    <= next_valid_d ? instF_in : NOP;
        validD   <= next_valid_d;
        instX    <= next_valid_x ? instD : NOP;
        validX   <= next_valid_x;
        kill_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Self-checking bench for pipeline_fetch_ctrl: directed test-plan scenarios,
// randomized traffic against a behavioural model, and kill-counter saturation.
module tb_pipeline_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  PCSel_F_in;
  logic        killD_req, killX_req, stall;
  logic [31:0] instF_in, immF, immD, aluX;
  logic [31:0] PCF, PCD, PCX, instD, instX;
  logic        validF, validD, validX;
  logic [15:0] kill_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_pcf, m_pcd, m_pcx, m_instd, m_instx;
  logic        m_vf, m_vd, m_vx;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] pc);
    return {pc[31:2] ^ 30'h02a5_f1c3, 2'b11};
  endfunction

  assign instF_in = imem(PCF);

  pipeline_fetch_ctrl #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
    .clk(clk), .rst_n(rst_n), .PCSel_F_in(PCSel_F_in),
    .killD_req(killD_req), .killX_req(killX_req), .stall(stall),
    .instF_in(instF_in), .immF(immF), .immD(immD), .aluX(aluX),
    .PCF(PCF), .PCD(PCD), .PCX(PCX), .instD(instD), .instX(instX),
    .validF(validF), .validD(validD), .validX(validX), .kill_cnt(kill_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".PCF"},    PCF,    m_pcf);
    check({tag, ".PCD"},    PCD,    m_pcd);
    check({tag, ".PCX"},    PCX,    m_pcx);
    check({tag, ".instD"},  instD,  m_instd);
    check({tag, ".instX"},  instX,  m_instx);
    check({tag, ".validF"}, {31'd0, validF}, {31'd0, m_vf});
    check({tag, ".validD"}, {31'd0, validD}, {31'd0, m_vd});
    check({tag, ".validX"}, {31'd0, validX}, {31'd0, m_vx});
    check({tag, ".kill_cnt"}, {16'd0, kill_cnt}, m_cnt);
  endtask

  // Apply one cycle of inputs, advance the model by the stage rules, compare at negedge.
  task automatic step(input string tag, input bit rst, input logic [2:0] sel,
                      input bit st, input bit kd, input bit kx,
                      input logic [31:0] i_f, input logic [31:0] i_d,
                      input logic [31:0] alu, input bit chk);
    logic [31:0] target;
    bit          is_redirect, killed_d, killed_x;
    rst_n = ~rst; PCSel_F_in = sel; stall = st; killD_req = kd; killX_req = kx;
    immF = i_f; immD = i_d; aluX = alu;
    if (rst) begin
      m_pcf = RST_PC; m_pcd = RST_PC; m_pcx = RST_PC;
      m_instd = NOP_W; m_instx = NOP_W;
      m_vf = 0; m_vd = 0; m_vx = 0; m_cnt = 0;
    end else begin
      case (sel)
        3'd1:    target = m_pcf + i_f;
        3'd2:    target = {alu[31:1], 1'b0};
        3'd3:    target = m_pcd + i_d;
        default: target = m_pcf + 32'd4;
      endcase
      is_redirect = m_vf && (sel == 3'd2 || sel == 3'd3);
      if (m_vf && st && !is_redirect) begin
        m_pcx = m_pcd; m_vx = 0; m_instx = NOP_W;
      end else begin
        killed_d = m_vf && kd;
        killed_x = m_vf && kx && m_vd;
        m_pcx   = m_pcd;
        m_vx    = m_vd && !(m_vf && kx);
        m_instx = m_vx ? m_instd : NOP_W;
        m_pcd   = m_pcf;
        m_vd    = m_vf && !kd;
        m_instd = m_vd ? imem(m_pcf) : NOP_W;
        m_cnt   = m_cnt + int'(killed_d) + int'(killed_x);
        if (m_cnt > 65535) m_cnt = 65535;
        if (m_vf) m_pcf = target;
      end
      m_vf = 1;
    end
    @(posedge clk);
    @(negedge clk);
    if (chk) check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; PCSel_F_in = '0; killD_req = 0; killX_req = 0; stall = 0;
    immF = '0; immD = '0; aluX = '0;
    @(negedge clk);

    // Reset and first fetch
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rst.validF", {31'd0, validF}, 32'd0);
    check("rst.instX", instX, 32'h13);
    check("rst.kill_cnt", {16'd0, kill_cnt}, 32'd0);
    step("rel", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("rel.PCF", PCF, 32'h100);
    check("rel.validF", {31'd0, validF}, 32'd1);
    step("seq1", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("seq1.PCF", PCF, 32'h104);
    step("seq2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("seq3", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("seq3.PCF", PCF, 32'h10C);

    // JAL backwards, then JAL forward to line PCD up on 0x200
    step("jal", 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 0, 0, 1);
    check("jal.PCF", PCF, 32'h0FC);
    check("jal.validX", {31'd0, validX}, 32'd1);
    check("jal.kill_cnt", {16'd0, kill_cnt}, 32'd0);
    step("jal2", 0, 1, 0, 0, 0, 32'h104, 0, 0, 1);
    step("fill", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("fill.PCD", PCD, 32'h200);

    // Taken branch in D
    step("br", 0, 3, 0, 1, 0, 0, 32'h40, 0, 1);
    check("br.PCF", PCF, 32'h240);
    check("br.validD", {31'd0, validD}, 32'd0);
    check("br.instD", instD, 32'h13);
    check("br.PCX", PCX, 32'h200);
    check("br.validX", {31'd0, validX}, 32'd1);
    check("br.kill_cnt", {16'd0, kill_cnt}, 32'd1);

    // JALR in X
    step("refill", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("jalr", 0, 2, 0, 1, 1, 0, 0, 32'h0000_0301, 1);
    check("jalr.PCF", PCF, 32'h300);
    check("jalr.validD", {31'd0, validD}, 32'd0);
    check("jalr.validX", {31'd0, validX}, 32'd0);
    check("jalr.kill_cnt", {16'd0, kill_cnt}, 32'd3);

    // Stall for two edges, then redirect overriding stall
    step("pre_st", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step("stall", 0, 0, 1, 0, 0, 0, 0, 0, 1);
      check("stall.PCF", PCF, 32'h304);
      check("stall.PCD", PCD, 32'h300);
      check("stall.instD", instD, imem(32'h300));
      check("stall.validX", {31'd0, validX}, 32'd0);
      check("stall.instX", instX, 32'h13);
    end
    step("st_br", 0, 3, 1, 1, 0, 0, 32'h10, 0, 1);
    check("st_br.PCF", PCF, 32'h310);
    check("st_br.PCD", PCD, 32'h304);

    // Randomized traffic, including occasional resets and wrap-prone immediates
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom, 1);
    end

    // Counter saturation: reset, fill D, then one killed X slot per edge
    step("sat_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("sat_rel", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("sat_fill", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    while (m_cnt < 16'hFFFE) step("sat_run", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    check_all("sat_pre");
    check("sat_pre.kill_cnt", {16'd0, kill_cnt}, 32'hFFFE);
    step("sat_jalr", 0, 2, 0, 1, 1, 0, 0, 32'h0000_0800, 1);
    check("sat.kill_cnt", {16'd0, kill_cnt}, 32'hFFFF);
    step("sat_more", 0, 0, 0, 0, 1, 0, 0, 0, 1);
    step("sat_more2", 0, 0, 0, 1, 1, 0, 0, 0, 1);
    check("sat_hold.kill_cnt", {16'd0, kill_cnt}, 32'hFFFF);

    // Mid-run reset overrides active redirect/kill inputs
    step("mid_rst", 1, 3, 1, 1, 1, 32'h40, 32'h40, 32'h40, 1);
    check("mid_rst.PCF", PCF, 32'h100);
    check("mid_rst.PCX", PCX, 32'h100);
    check("mid_rst.instD", instD, 32'h13);
    check("mid_rst.validD", {31'd0, validD}, 32'd0);
    check("mid_rst.kill_cnt", {16'd0, kill_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
